// File: rtl/online_mult_pkg.sv
// Shared digit encoding, online delay and controller state type for the
// signed-digit online multiplier.
package online_mult_pkg;

  localparam int DELTA = 3;

  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } olm_state_e;

  // Both 00 and 11 decode to zero.
  function automatic logic signed [1:0] dig_to_int(input logic [1:0] d);
    case (d)
      DIG_POS: return 2'sd1;
      DIG_NEG: return -2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

  function automatic logic [1:0] int_to_dig(input logic signed [1:0] v);
    if (v > 2'sd0)      return DIG_POS;
    else if (v < 2'sd0) return DIG_NEG;
    else                return DIG_ZERO;
  endfunction

endpackage

// File: rtl/olm_residual_step.sv
// One recurrence step of the online multiplier: operand append, residual
// update V = 2W + (X*yd + Y'*xd)*2^-DELTA, digit selection and W' = V - p.
module olm_residual_step
  import online_mult_pkg::*;
#(
  parameter int PRECISION = 16,
  parameter int CNT_W     = $clog2(PRECISION + 3) + 1
) (
  input  logic signed [PRECISION+1:0]       x,
  input  logic signed [PRECISION+1:0]       y,
  input  logic signed [PRECISION+DELTA+2:0] w,
  input  logic [1:0]                        xd,
  input  logic [1:0]                        yd,
  input  logic [CNT_W-1:0]                  i,
  input  logic                              sel_en,
  output logic signed [PRECISION+1:0]       x_next,
  output logic signed [PRECISION+1:0]       y_next,
  output logic signed [PRECISION+DELTA+2:0] w_next,
  output logic [1:0]                        p
);

  localparam int W_W = PRECISION + DELTA + 3;
  // Weight 1.0 in residual units (LSB = 2^-(PRECISION+DELTA)).
  localparam logic signed [W_W-1:0] ONE = {3'b001, {(PRECISION + DELTA){1'b0}}};

  logic signed [PRECISION+1:0] unit;
  logic signed [1:0]           xv, yv, ps;
  logic signed [W_W-1:0]       x_ext, y_ext, tx, ty, v;
  logic signed [4:0]           vt;

  // Weight 2^-i in operand units; zero once i runs past the operand length.
  always_comb begin
    unit = '0;
    for (int b = 1; b <= PRECISION; b++) begin
      if (int'(i) == b) unit[PRECISION-b] = 1'b1;
    end
  end

  // Residual recurrence and digit selection on a 2-fraction-bit estimate.
  always_comb begin
    xv = dig_to_int(xd);
    yv = dig_to_int(yd);
    if (yv == 2'sd1)       y_next = y + unit;
    else if (yv == -2'sd1) y_next = y - unit;
    else                   y_next = y;
    if (xv == 2'sd1)       x_next = x + unit;
    else if (xv == -2'sd1) x_next = x - unit;
    else                   x_next = x;
    // Operand LSB times 2^-DELTA lands exactly on the residual LSB.
    x_ext = {{(W_W - PRECISION - 2){x[PRECISION+1]}}, x};
    y_ext = {{(W_W - PRECISION - 2){y_next[PRECISION+1]}}, y_next};
    if (yv == 2'sd1)       tx = x_ext;
    else if (yv == -2'sd1) tx = -x_ext;
    else                   tx = '0;
    if (xv == 2'sd1)       ty = y_ext;
    else if (xv == -2'sd1) ty = -y_ext;
    else                   ty = '0;
    v  = (w <<< 1) + tx + ty;
    vt = v[W_W-1 -: 5];
    ps = 2'sd0;
    if (sel_en) begin
      if (vt >= 5'sd2)       ps = 2'sd1;
      else if (vt <= -5'sd3) ps = -2'sd1;
    end
    if (ps == 2'sd1)       w_next = v - ONE;
    else if (ps == -2'sd1) w_next = v + ONE;
    else                   w_next = v;
    p = int_to_dig(ps);
  end

endmodule

// File: rtl/online_mult_param_hd.sv
// Radix-2 signed-digit online multiplier, MSD first, online delay DELTA.
// Holds operand/residual registers, step counter, join handshake and a
// single output register with back-pressure.
//
//   state   | meaning
//   FILL    | k < DELTA: consume inputs, no output
//   RUN     | DELTA <= k < PRECISION: consume inputs, emit digits
//   TAIL    | k >= PRECISION: zero inputs, emit remaining digits
module online_mult_param_hd
  import online_mult_pkg::*;
#(
  parameter int PRECISION = 16,
  parameter int CNT_W     = $clog2(PRECISION + 3) + 1
) (
  input  logic       clk,
  input  logic       asyn_reset,
  input  logic [1:0] x_value,
  input  logic       data_x_vld,
  output logic       data_x_rdy,
  input  logic [1:0] y_value,
  input  logic       data_y_vld,
  output logic       data_y_rdy,
  output logic [1:0] p_value,
  output logic       data_out_vld,
  input  logic       data_out_rdy,
  output logic       data_out_last,
  input  logic       clear,
  output logic       busy
);

  localparam int W_W = PRECISION + DELTA + 3;
  localparam logic [CNT_W-1:0] K_RUN  = CNT_W'(DELTA);
  localparam logic [CNT_W-1:0] K_TAIL = CNT_W'(PRECISION);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(PRECISION + DELTA - 1);

  olm_state_e                  state, state_next;
  logic [CNT_W-1:0]            k, k_next, i;
  logic signed [PRECISION+1:0] x_r, y_r, x_n, y_n;
  logic signed [W_W-1:0]       w_r, w_n;
  logic [1:0]                  xd, yd, p_n;
  logic                        out_ok, in_ok, step, sel_en, frame_end;

  assign i         = k + CNT_W'(1);
  assign frame_end = step && (k == K_LAST);
  assign busy      = (k != '0) || data_out_vld;

  olm_residual_step #(.PRECISION(PRECISION), .CNT_W(CNT_W)) u_step (
    .x      (x_r),
    .y      (y_r),
    .w      (w_r),
    .xd     (xd),
    .yd     (yd),
    .i      (i),
    .sel_en (sel_en),
    .x_next (x_n),
    .y_next (y_n),
    .w_next (w_n),
    .p      (p_n)
  );

  // State and step counter register.
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      state <= ST_FILL;
      k     <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
    end
  end

  // Next state follows the counter; clear and frame end both restart at FILL.
  always_comb begin
    state_next = state;
    k_next     = k;
    if (clear || frame_end) begin
      state_next = ST_FILL;
      k_next     = '0;
    end else if (step) begin
      k_next = k + CNT_W'(1);
      if (k_next < K_RUN)       state_next = ST_FILL;
      else if (k_next < K_TAIL) state_next = ST_RUN;
      else                      state_next = ST_TAIL;
    end
  end

  // Handshake, step enable and digit source per state.
  always_comb begin
    out_ok     = !data_out_vld || data_out_rdy;
    in_ok      = (state != ST_TAIL) && !clear && ((state == ST_FILL) || out_ok);
    data_x_rdy = in_ok && data_y_vld;
    data_y_rdy = in_ok && data_x_vld;
    sel_en     = (state != ST_FILL);
    xd         = DIG_ZERO;
    yd         = DIG_ZERO;
    step       = 1'b0;
    case (state)
      ST_FILL, ST_RUN: begin
        step = in_ok && data_x_vld && data_y_vld;
        xd   = x_value;
        yd   = y_value;
      end
      default: step = out_ok && !clear;
    endcase
  end

  // Operand and residual registers; zeroed between frames.
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      x_r <= '0;
      y_r <= '0;
      w_r <= '0;
    end else if (clear || frame_end) begin
      x_r <= '0;
      y_r <= '0;
      w_r <= '0;
    end else if (step) begin
      x_r <= x_n;
      y_r <= y_n;
      w_r <= w_n;
    end
  end

  // Output register: load on emitting steps, hold until drained.
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      p_value       <= DIG_ZERO;
      data_out_vld  <= 1'b0;
      data_out_last <= 1'b0;
    end else if (clear) begin
      p_value       <= DIG_ZERO;
      data_out_vld  <= 1'b0;
      data_out_last <= 1'b0;
    end else if (step && sel_en) begin
      p_value       <= p_n;
      data_out_vld  <= 1'b1;
      data_out_last <= (k == K_LAST);
    end else if (data_out_rdy) begin
      data_out_vld  <= 1'b0;
      data_out_last <= 1'b0;
    end
  end

endmodule
